// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl - valid/ready command sequencer around a small ALU with a register file and iterative MUL.
// Rev 1.0
`default_nettype none

module alu_seq_ctrl #(
   parameter int WIDTH  = 6,
   parameter int NREG   = 4,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [1:0]       cmd_rd,
   input  logic [1:0]       cmd_rs1,
   input  logic [1:0]       cmd_rs2,
   input  logic             cmd_imm_sel,
   input  logic [WIDTH-1:0] cmd_imm,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_carry,
   output logic             res_zero,
   output logic             res_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_SLT = 4'b1000;
   localparam logic [3:0] OP_MUL = 4'b1001;
   localparam int         CNT_W  = $clog2(WIDTH + 1);

   state_t             state_q;
   logic [WIDTH-1:0]   regs_q [NREG];
   logic               cmd_ready_q;
   logic               res_valid_q;
   logic [WIDTH-1:0]   res_data_q;
   logic               res_carry_q;
   logic               res_zero_q;
   logic               res_err_q;
   logic [1:0]         rd_q;
   logic [2*WIDTH-1:0] mul_a_q;
   logic [2*WIDTH-1:0] mul_acc_q;
   logic [WIDTH-1:0]   mul_b_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [WIDTH-1:0]   opa;
   logic [WIDTH-1:0]   opb;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_carry;
   logic               op_undef;
   logic [WIDTH:0]     sum_ext;
   logic [WIDTH:0]     diff_ext;
   logic [2*WIDTH-1:0] mul_acc_d;
   logic               accept;

   assign cmd_ready = cmd_ready_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_carry = res_carry_q;
   assign res_zero  = res_zero_q;
   assign res_err   = res_err_q;

   // r0 is held at zero in the array itself, so reads need no special case.
   always_comb begin
      opa       = regs_q[cmd_rs1];
      opb       = cmd_imm_sel ? cmd_imm : regs_q[cmd_rs2];
      sum_ext   = {1'b0, opa} + {1'b0, opb};
      diff_ext  = {1'b0, opa} - {1'b0, opb};
      alu_res   = '0;
      alu_carry = 1'b0;
      op_undef  = 1'b0;
      case (cmd_op)
         OP_AND: alu_res = opa & opb;
         OP_OR:  alu_res = opa | opb;
         OP_XOR: alu_res = opa ^ opb;
         OP_ADD: begin
            alu_res   = sum_ext[WIDTH-1:0];
            alu_carry = sum_ext[WIDTH];
         end
         OP_SUB: begin
            alu_res   = diff_ext[WIDTH-1:0];
            alu_carry = diff_ext[WIDTH];
         end
         OP_SLL: alu_res = opa << opb[2:0];
         OP_SRL: alu_res = opa >> opb[2:0];
         OP_SRA: alu_res = $unsigned($signed(opa) >>> opb[2:0]);
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
         OP_MUL: op_undef = !MUL_EN;
         default: op_undef = 1'b1;
      endcase
   end

   assign mul_acc_d = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
   assign accept    = cmd_valid && cmd_ready_q && (state_q == S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_carry_q <= 1'b0;
         res_zero_q  <= 1'b0;
         res_err_q   <= 1'b0;
         rd_q        <= '0;
         mul_a_q     <= '0;
         mul_acc_q   <= '0;
         mul_b_q     <= '0;
         cnt_q       <= '0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  cmd_ready_q <= 1'b0;
                  if (op_undef) begin
                     state_q     <= S_DONE;
                     res_valid_q <= 1'b1;
                     res_data_q  <= '0;
                     res_carry_q <= 1'b0;
                     res_zero_q  <= 1'b1;
                     res_err_q   <= 1'b1;
                  end else if (cmd_op == OP_MUL) begin
                     state_q   <= S_MUL;
                     rd_q      <= cmd_rd;
                     mul_a_q   <= {{WIDTH{1'b0}}, opa};
                     mul_b_q   <= opb;
                     mul_acc_q <= '0;
                     cnt_q     <= '0;
                  end else begin
                     state_q     <= S_DONE;
                     res_valid_q <= 1'b1;
                     res_data_q  <= alu_res;
                     res_carry_q <= alu_carry;
                     res_zero_q  <= (alu_res == '0);
                     res_err_q   <= 1'b0;
                     if (cmd_rd != 2'd0) regs_q[cmd_rd] <= alu_res;
                  end
               end else begin
                  cmd_ready_q <= 1'b1;
               end
            end
            S_MUL: begin
               // Shift-and-add: A moves left, B right, one partial product per cycle.
               mul_acc_q <= mul_acc_d;
               mul_a_q   <= mul_a_q << 1;
               mul_b_q   <= mul_b_q >> 1;
               cnt_q     <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q     <= S_DONE;
                  res_valid_q <= 1'b1;
                  res_data_q  <= mul_acc_d[WIDTH-1:0];
                  res_carry_q <= |mul_acc_d[2*WIDTH-1:WIDTH];
                  res_zero_q  <= (mul_acc_d[WIDTH-1:0] == '0);
                  res_err_q   <= 1'b0;
                  if (rd_q != 2'd0) regs_q[rd_q] <= mul_acc_d[WIDTH-1:0];
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  state_q     <= S_IDLE;
                  res_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               res_valid_q <= 1'b0;
               cmd_ready_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl - directed and randomized checks of alu_seq_ctrl against an arithmetic reference model.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_alu_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_op = '0;
   logic [1:0] cmd_rd = '0;
   logic [1:0] cmd_rs1 = '0;
   logic [1:0] cmd_rs2 = '0;
   logic       cmd_imm_sel = 1'b0;
   logic [5:0] cmd_imm = '0;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [5:0] res_data;
   logic       res_carry;
   logic       res_zero;
   logic       res_err;

   int n_checks = 0;
   int n_fail   = 0;
   int mreg [4];
   int last_data, last_carry, last_zero, last_err;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.WIDTH(6), .NREG(4), .MUL_EN(1'b1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_rd     (cmd_rd),
      .cmd_rs1    (cmd_rs1),
      .cmd_rs2    (cmd_rs2),
      .cmd_imm_sel(cmd_imm_sel),
      .cmd_imm    (cmd_imm),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_carry  (res_carry),
      .res_zero   (res_zero),
      .res_err    (res_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference ALU on plain integers (6-bit values).
   function automatic void model(input int op, input int a, input int b,
                                 output int res, output int c, output int e);
      int amt, sa, sb, p;
      amt = b % 8;
      sa  = (a >= 32) ? a - 64 : a;
      sb  = (b >= 32) ? b - 64 : b;
      res = 0; c = 0; e = 0;
      case (op)
         0: res = a & b;
         1: res = a | b;
         2: begin p = a + b; res = p % 64; c = (p >= 64) ? 1 : 0; end
         3: res = (a * (1 << amt)) % 64;
         4: res = a ^ b;
         5: res = a / (1 << amt);
         6: begin res = (a - b + 64) % 64; c = (a < b) ? 1 : 0; end
         7: res = (sa >>> amt) & 63;
         8: res = (sa < sb) ? 1 : 0;
         9: begin p = a * b; res = p % 64; c = (p >= 64) ? 1 : 0; end
         default: e = 1;
      endcase
   endfunction

   task automatic run(input int op, input int rd, input int rs1, input int rs2,
                      input int sel, input int imm, input int hold);
      int a, b, er, ec, ee, lat, wn;
      a = mreg[rs1];
      b = (sel != 0) ? imm : mreg[rs2];
      model(op, a, b, er, ec, ee);
      wn = 0;
      while (cmd_ready !== 1'b1 && wn < 10) begin
         @(negedge clk);
         wn++;
      end
      check("cmd_ready_before_issue", cmd_ready, 1);
      cmd_valid   = 1'b1;
      cmd_op      = op[3:0];
      cmd_rd      = rd[1:0];
      cmd_rs1     = rs1[1:0];
      cmd_rs2     = rs2[1:0];
      cmd_imm_sel = sel[0];
      cmd_imm     = imm[5:0];
      res_ready   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (res_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, (op == 9) ? 7 : 1);
      check("res_data", res_data, er);
      check("res_carry", res_carry, ec);
      check("res_zero", res_zero, (er == 0) ? 1 : 0);
      check("res_err", res_err, ee);
      last_data = int'(res_data); last_carry = int'(res_carry);
      last_zero = int'(res_zero); last_err = int'(res_err);
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1;
         cmd_op    = 4'($urandom);
         cmd_rd    = 2'($urandom);
         cmd_rs1   = 2'($urandom);
         cmd_imm   = 6'($urandom);
         @(negedge clk);
         check("hold_valid", res_valid, 1);
         check("hold_data", res_data, er);
         check("hold_cmd_ready", cmd_ready, 0);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("release_valid", res_valid, 0);
      check("release_cmd_ready", cmd_ready, 1);
      if (ee == 0 && rd != 0) mreg[rd] = er;
   endtask

   task automatic read_reg(input int idx, input int exp, input string tag);
      run(1, 0, idx, 0, 1, 0, 0);
      check(tag, last_data, exp);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) mreg[i] = 0;
      #1;
      check("reset_cmd_ready", cmd_ready, 0);
      check("reset_res_valid", res_valid, 0);
      check("reset_res_data", res_data, 0);
      check("reset_res_carry", res_carry, 0);
      check("reset_res_zero", res_zero, 0);
      check("reset_res_err", res_err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run(2, 1, 0, 0, 1, 63, 0);
      check("add63_data", last_data, 63);
      check("add63_carry", last_carry, 0);
      run(2, 2, 1, 0, 1, 1, 0);
      check("add_wrap_data", last_data, 0);
      check("add_wrap_carry", last_carry, 1);
      check("add_wrap_zero", last_zero, 1);
      read_reg(2, 0, "r2_after_wrap");

      run(2, 1, 0, 0, 1, 5, 0);
      run(6, 3, 1, 0, 1, 9, 0);
      check("sub_data", last_data, 60);
      check("sub_borrow", last_carry, 1);
      run(2, 1, 0, 0, 1, 60, 0);
      run(8, 3, 1, 0, 1, 3, 0);
      check("slt_data", last_data, 1);

      run(2, 1, 0, 0, 1, 32, 0);
      run(7, 2, 1, 0, 1, 3, 0);
      check("sra_data", last_data, 60);
      run(5, 2, 1, 0, 1, 6, 0);
      check("srl6_data", last_data, 0);
      check("srl6_zero", last_zero, 1);
      run(2, 1, 0, 0, 1, 3, 0);
      run(3, 2, 1, 0, 1, 2, 0);
      check("sll_data", last_data, 12);

      run(2, 1, 0, 0, 1, 7, 0);
      run(9, 2, 1, 0, 1, 9, 0);
      check("mul7x9_data", last_data, 63);
      check("mul7x9_carry", last_carry, 0);
      run(2, 1, 0, 0, 1, 8, 0);
      run(9, 3, 1, 0, 1, 8, 0);
      check("mul8x8_data", last_data, 0);
      check("mul8x8_carry", last_carry, 1);
      check("mul8x8_zero", last_zero, 1);

      run(2, 3, 0, 0, 1, 21, 5);
      run(11, 3, 1, 2, 0, 0, 0);
      check("undef_err", last_err, 1);
      read_reg(3, 21, "undef_rd_unchanged");

      for (int n = 0; n < 200; n++) begin
         int op;
         op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
         run(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
      end

      // Abort a MUL in flight with an asynchronous reset.
      run(2, 1, 0, 0, 1, 13, 0);
      run(2, 2, 0, 0, 1, 42, 0);
      cmd_valid = 1'b1; cmd_op = 4'd9; cmd_rd = 2'd3; cmd_rs1 = 2'd1;
      cmd_imm_sel = 1'b1; cmd_imm = 6'd11;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_res_valid", res_valid, 0);
      check("abort_cmd_ready", cmd_ready, 0);
      for (int i = 0; i < 4; i++) mreg[i] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("after_abort_cmd_ready", cmd_ready, 1);
      check("after_abort_res_valid", res_valid, 0);
      read_reg(1, 0, "abort_r1_cleared");
      read_reg(2, 0, "abort_r2_cleared");
      read_reg(3, 0, "abort_r3_cleared");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
